// File: rtl/vrc_pkg.sv
// vrc_pkg: shared defaults and types for vector_range_compactor.
package vrc_pkg;

    localparam int unsigned VRC_N_ELEM = 12;
    localparam int unsigned VRC_DATA_W = 8;
    localparam int unsigned VRC_IDX_W  = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    typedef logic [VRC_DATA_W-1:0] elem_t;

endpackage

// File: rtl/vrc_next_set.sv
// vrc_next_set: finds the lowest set mask bit at or above a start index.
module vrc_next_set
    import vrc_pkg::*;
#(
    parameter int unsigned N_ELEM = VRC_N_ELEM,
    parameter int unsigned IDX_W  = VRC_IDX_W
) (
    input  logic [N_ELEM-1:0] i_mask,
    input  logic [IDX_W-1:0]  i_start,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_none
);

    always_comb begin
        o_idx  = '0;
        o_none = 1'b1;
        // Scan downward so the lowest qualifying index is the final assignment.
        for (int unsigned i = N_ELEM; i > 0; i--) begin
            if (i_mask[i-1] && ((i - 1) >= 32'(i_start))) begin
                o_idx  = IDX_W'(i - 1);
                o_none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vector_range_compactor.sv
// vector_range_compactor: streams the in-range elements of each checked vector.
// Optional VRC_PREFETCH_EN adds a second holding register for back-to-back vectors.
module vector_range_compactor
    import vrc_pkg::*;
#(
    parameter int unsigned N_ELEM = VRC_N_ELEM,
    parameter int unsigned DATA_W = VRC_DATA_W,
    parameter int unsigned IDX_W  = VRC_IDX_W
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_ELEM*DATA_W-1:0]   in_vector,
    input  logic [N_ELEM-1:0]          in_error,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [IDX_W-1:0]           out_index,
    output logic                       out_last,
    output logic [IDX_W-1:0]           err_count,
    output logic                       vec_done,
    output logic                       all_err
);

    state_t                     r_state;
    logic [N_ELEM*DATA_W-1:0]   r_buf;
    logic [N_ELEM-1:0]          r_mask;
    logic [IDX_W-1:0]           r_ptr;
    logic [IDX_W-1:0]           r_nxt;
    logic [IDX_W-1:0]           r_err_count;
    logic [DATA_W-1:0]          r_out_data;
    logic                       r_out_valid;
    logic                       r_out_last;
    logic                       r_vec_done;
    logic                       r_all_err;

`ifdef VRC_PREFETCH_EN
    logic [N_ELEM*DATA_W-1:0]   r_hold_vec;
    logic [N_ELEM-1:0]          r_hold_mask;
    logic [IDX_W-1:0]           r_hold_err;
    logic                       r_hold_full;
    logic                       r_pend_allerr;
`endif

    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_beat;
    logic                       w_fin;
    logic                       w_load;
    logic [IDX_W-1:0]           w_in_popcnt;
    logic [N_ELEM*DATA_W-1:0]   w_ld_vec;
    logic [N_ELEM-1:0]          w_ld_mask;
    logic [IDX_W-1:0]           w_ld_err;
    logic [IDX_W-1:0]           w_first_idx;
    logic                       w_first_none;
    logic [N_ELEM*DATA_W-1:0]   w_cur_buf;
    logic [N_ELEM-1:0]          w_cur_mask;
    logic [IDX_W-1:0]           w_cur_idx;
    logic [IDX_W-1:0]           w_nxt_start;
    logic [IDX_W-1:0]           w_nxt_idx;
    logic                       w_nxt_none;
    logic [DATA_W-1:0]          w_cur_data;

    always_comb begin
        w_in_popcnt = '0;
        for (int unsigned i = 0; i < N_ELEM; i++) begin
            w_in_popcnt = w_in_popcnt + IDX_W'(in_error[i]);
        end
    end

    always_comb begin
        w_in_ready = 1'b0;
        if (!reset) begin
            case (r_state)
`ifdef VRC_PREFETCH_EN
                IDLE:    w_in_ready = !r_pend_allerr;
                STREAM:  w_in_ready = !r_hold_full;
`else
                IDLE:    w_in_ready = 1'b1;
                STREAM:  w_in_ready = 1'b0;
`endif
                default: w_in_ready = 1'b0;
            endcase
        end
    end

    assign w_accept = in_valid && w_in_ready;
    assign w_beat   = r_out_valid && out_ready;
    assign w_fin    = w_beat && r_out_last;

`ifdef VRC_PREFETCH_EN
    // A held vector takes priority; otherwise an accept on the final beat loads directly.
    assign w_ld_vec  = r_hold_full ? r_hold_vec  : in_vector;
    assign w_ld_mask = r_hold_full ? r_hold_mask : ~in_error;
    assign w_ld_err  = r_hold_full ? r_hold_err  : w_in_popcnt;
    assign w_load    = (w_accept && (r_state == IDLE)) || (w_fin && (r_hold_full || w_accept));
`else
    assign w_ld_vec  = in_vector;
    assign w_ld_mask = ~in_error;
    assign w_ld_err  = w_in_popcnt;
    assign w_load    = w_accept;
`endif

    vrc_next_set #(
        .N_ELEM (N_ELEM),
        .IDX_W  (IDX_W)
    ) u_first (
        .i_mask  (w_ld_mask),
        .i_start ('0),
        .o_idx   (w_first_idx),
        .o_none  (w_first_none)
    );

    // The pointer that becomes current this edge, and the lookup above it that
    // yields both the following pointer and the last flag.
    assign w_cur_buf   = w_load ? w_ld_vec    : r_buf;
    assign w_cur_mask  = w_load ? w_ld_mask   : r_mask;
    assign w_cur_idx   = w_load ? w_first_idx : r_nxt;
    assign w_nxt_start = w_cur_idx + 1'b1;

    vrc_next_set #(
        .N_ELEM (N_ELEM),
        .IDX_W  (IDX_W)
    ) u_next (
        .i_mask  (w_cur_mask),
        .i_start (w_nxt_start),
        .o_idx   (w_nxt_idx),
        .o_none  (w_nxt_none)
    );

    always_comb begin
        w_cur_data = '0;
        for (int unsigned i = 0; i < N_ELEM; i++) begin
            if (w_cur_idx == IDX_W'(i)) begin
                w_cur_data = w_cur_buf[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_buf         <= '0;
            r_mask        <= '0;
            r_ptr         <= '0;
            r_nxt         <= '0;
            r_err_count   <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_vec_done    <= 1'b0;
            r_all_err     <= 1'b0;
`ifdef VRC_PREFETCH_EN
            r_hold_vec    <= '0;
            r_hold_mask   <= '0;
            r_hold_err    <= '0;
            r_hold_full   <= 1'b0;
            r_pend_allerr <= 1'b0;
`endif
        end else begin
            r_vec_done <= 1'b0;
            r_all_err  <= 1'b0;

            if (w_fin) begin
                r_vec_done  <= 1'b1;
                r_state     <= IDLE;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else if (w_beat) begin
                r_ptr      <= w_cur_idx;
                r_nxt      <= w_nxt_idx;
                r_out_data <= w_cur_data;
                r_out_last <= w_nxt_none;
            end

`ifdef VRC_PREFETCH_EN
            if (r_pend_allerr) begin
                r_pend_allerr <= 1'b0;
                r_all_err     <= 1'b1;
                r_vec_done    <= 1'b1;
            end
            if (w_accept && (r_state == STREAM) && !w_fin) begin
                r_hold_vec  <= in_vector;
                r_hold_mask <= ~in_error;
                r_hold_err  <= w_in_popcnt;
                r_hold_full <= 1'b1;
            end
            if (w_fin && r_hold_full) begin
                r_hold_full <= 1'b0;
            end
`endif

            if (w_load) begin
                r_buf       <= w_ld_vec;
                r_mask      <= w_ld_mask;
                r_err_count <= w_ld_err;
                if (w_first_none) begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
`ifdef VRC_PREFETCH_EN
                    // The streamed vector already owns this edge's vec_done; defer by one.
                    if (w_fin) begin
                        r_pend_allerr <= 1'b1;
                    end else begin
                        r_all_err  <= 1'b1;
                        r_vec_done <= 1'b1;
                    end
`else
                    r_all_err  <= 1'b1;
                    r_vec_done <= 1'b1;
`endif
                end else begin
                    r_state     <= STREAM;
                    r_out_valid <= 1'b1;
                    r_ptr       <= w_cur_idx;
                    r_nxt       <= w_nxt_idx;
                    r_out_data  <= w_cur_data;
                    r_out_last  <= w_nxt_none;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_index = r_ptr;
    assign out_last  = r_out_last;
    assign err_count = r_err_count;
    assign vec_done  = r_vec_done;
    assign all_err   = r_all_err;

endmodule

// File: tb/tb_vector_range_compactor.sv
// Self-checking bench for vector_range_compactor: directed table, corner sequences, random vs model.
module tb_vector_range_compactor;

    localparam int N  = 12;
    localparam int DW = 8;
    localparam int IW = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [N*DW-1:0] in_vector = '0;
    logic [N-1:0]    in_error = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_index;
    logic            out_last;
    logic [IW-1:0]   err_count;
    logic            vec_done;
    logic            all_err;

    vector_range_compactor #(
        .N_ELEM (N),
        .DATA_W (DW),
        .IDX_W  (IW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vector (in_vector),
        .in_error  (in_error),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .err_count (err_count),
        .vec_done  (vec_done),
        .all_err   (all_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] d;
        logic [3:0] idx;
        logic       last;
        logic [3:0] ec;
        int         stamp;
    } beat_t;

    typedef struct {
        logic [N*DW-1:0] v;
        logic [N-1:0]    e;
        int              mode;
        int              n;
        logic [3:0]      ec;
        logic [3:0]      lidx;
    } vec_rec_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    rdy_mode = 0;
    int    done_cnt = 0;
    int    allerr_cnt = 0;
    int    done_stamp = 0;
    beat_t q_beats[$];
    beat_t exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Output monitor: records transferred beats and pulses, and checks stall stability.
    logic       p_stall = 1'b0;
    logic [7:0] p_d;
    logic [3:0] p_i;
    logic       p_l;
    always @(negedge clock) begin
        if (reset) begin
            p_stall = 1'b0;
        end else begin
            if (p_stall) begin
                chk("stall_hold_valid", 32'(out_valid), 32'd1);
                chk("stall_hold_data",  32'(out_data),  32'(p_d));
                chk("stall_hold_index", 32'(out_index), 32'(p_i));
                chk("stall_hold_last",  32'(out_last),  32'(p_l));
            end
            p_stall = out_valid && !out_ready;
            p_d = out_data;
            p_i = out_index;
            p_l = out_last;
            if (out_valid && out_ready) begin
                beat_t b;
                b.d = out_data;
                b.idx = out_index;
                b.last = out_last;
                b.ec = err_count;
                b.stamp = cyc;
                q_beats.push_back(b);
            end
            if (vec_done) begin
                done_cnt++;
                done_stamp = cyc;
            end
            if (all_err) allerr_cnt++;
        end
    end

    function automatic logic [N*DW-1:0] mkvec(input int base, input int step);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = 8'(base + i * step);
        return v;
    endfunction

    // Reference: every element whose error bit is clear, in index order.
    function automatic int model(input logic [N*DW-1:0] v, input logic [N-1:0] e);
        int ec;
        ec = $countones(e);
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            if (!e[i]) begin
                beat_t b;
                b.d = v[i*DW +: DW];
                b.idx = 4'(i);
                b.last = 1'b0;
                b.ec = 4'(ec);
                b.stamp = 0;
                exp_q.push_back(b);
            end
        end
        if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
        return ec;
    endfunction

    task automatic send(input logic [N*DW-1:0] v, input logic [N-1:0] e, output int stamp);
        int w;
        w = 0;
        stamp = -1;
        while (w < 100) begin
            @(negedge clock);
            #1;
            if (in_ready) begin
                in_vector = v;
                in_error = e;
                in_valid = 1'b1;
                @(posedge clock);
                #1;
                in_valid = 1'b0;
                stamp = cyc;
                break;
            end
            w++;
        end
        chk("accept_within_bound", 32'(stamp >= 0), 32'd1);
    endtask

    task automatic wait_done(input int target);
        int w;
        w = 0;
        while (done_cnt < target && w < 400) begin
            @(negedge clock);
            w++;
        end
        repeat (3) @(negedge clock);
        chk("vec_done_within_bound", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic run_vec(input logic [N*DW-1:0] v, input logic [N-1:0] e, input int mode);
        int ec;
        int d0;
        int a0;
        int st;
        int n;
        ec = model(v, e);
        rdy_mode = mode;
        q_beats.delete();
        d0 = done_cnt;
        a0 = allerr_cnt;
        send(v, e, st);
        wait_done(d0 + 1);
        n = exp_q.size();
        chk("beat_count", 32'(q_beats.size()), 32'(n));
        chk("vec_done_once", 32'(done_cnt - d0), 32'd1);
        chk("all_err_pulses", 32'(allerr_cnt - a0), 32'(n == 0));
        chk("err_count", 32'(err_count), 32'(ec));
        for (int k = 0; k < n && k < q_beats.size(); k++) begin
            chk("beat_data",  32'(q_beats[k].d),    32'(exp_q[k].d));
            chk("beat_index", 32'(q_beats[k].idx),  32'(exp_q[k].idx));
            chk("beat_last",  32'(q_beats[k].last), 32'(exp_q[k].last));
            chk("beat_errcnt", 32'(q_beats[k].ec),  32'(exp_q[k].ec));
            if (mode == 0) chk("beat_cycle", 32'(q_beats[k].stamp), 32'(st + k));
        end
        if (mode == 0 && n > 0) chk("done_with_last", 32'(done_stamp), 32'(st + n));
        if (n == 0) begin
            chk("allerr_done_cycle", 32'(done_stamp), 32'(st));
            chk("allerr_in_ready", 32'(in_ready), 32'd1);
        end
    endtask

    vec_rec_t tbl[7];

    initial begin
        int st;
        int d0;
        logic [N*DW-1:0] v;
        logic [N-1:0] e;
        int r;

        fork
            forever begin
                @(posedge clock);
                #1;
                case (rdy_mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = ~out_ready;
                    3:       out_ready = 1'b0;
                    default: out_ready = ($urandom_range(0, 3) != 0);
                endcase
            end
        join_none

        #12;
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_vec_done",  32'(vec_done),  32'd0);
        chk("rst_all_err",   32'(all_err),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        @(negedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        tbl[0] = '{mkvec(1, 1),   12'h000, 0, 12, 4'd0,  4'd11};
        tbl[1] = '{mkvec(16, 1),  12'hA55, 0, 6,  4'd6,  4'd10};
        tbl[2] = '{mkvec(200, 7), 12'hFFF, 0, 0,  4'd12, 4'd0};
        tbl[3] = '{mkvec(5, 3),   12'h7FF, 1, 1,  4'd11, 4'd11};
        tbl[4] = '{mkvec(9, 2),   12'h001, 2, 11, 4'd1,  4'd11};
        tbl[5] = '{mkvec(100, 5), 12'h800, 1, 11, 4'd1,  4'd10};
        tbl[6] = '{mkvec(77, 13), 12'h0F0, 0, 8,  4'd4,  4'd11};
        for (int t = 0; t < 7; t++) begin
            run_vec(tbl[t].v, tbl[t].e, tbl[t].mode);
            chk("tbl_beats", 32'(q_beats.size()), 32'(tbl[t].n));
            chk("tbl_errcnt", 32'(err_count), 32'(tbl[t].ec));
            if (tbl[t].n > 0 && q_beats.size() > 0)
                chk("tbl_last_idx", 32'(q_beats[q_beats.size()-1].idx), 32'(tbl[t].lidx));
        end

        // Single beat held by a stalled sink.
        v = mkvec(5, 3);
        rdy_mode = 3;
        q_beats.delete();
        d0 = done_cnt;
        send(v, 12'h7FF, st);
        repeat (4) begin
            @(negedge clock);
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_index", 32'(out_index), 32'd11);
            chk("stall_last",  32'(out_last),  32'd1);
            chk("stall_data",  32'(out_data),  32'h26);
        end
        chk("stall_no_done", 32'(done_cnt - d0), 32'd0);
        rdy_mode = 0;
        wait_done(d0 + 1);
        chk("stall_beats", 32'(q_beats.size()), 32'd1);

        // Reset during the third beat discards the vector.
        rdy_mode = 0;
        d0 = done_cnt;
        send(mkvec(1, 1), 12'h000, st);
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        chk("pre_rst_index", 32'(out_index), 32'd2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
        chk("mid_rst_out_data",  32'(out_data),  32'd0);
        chk("mid_rst_out_index", 32'(out_index), 32'd0);
        chk("mid_rst_err_count", 32'(err_count), 32'd0);
        chk("mid_rst_out_last",  32'(out_last),  32'd0);
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_no_done", 32'(done_cnt - d0), 32'd0);
        run_vec(mkvec(40, 1), 12'h007, 0);
        if (q_beats.size() > 0) chk("post_rst_first_idx", 32'(q_beats[0].idx), 32'd3);

`ifdef VRC_PREFETCH_EN
        // Back-to-back vectors through the holding register.
        rdy_mode = 0;
        q_beats.delete();
        d0 = done_cnt;
        send(mkvec(1, 1), 12'h000, st);
        send(mkvec(50, 1), 12'hFF0, r);
        wait_done(d0 + 2);
        chk("pf_beats", 32'(q_beats.size()), 32'd16);
        chk("pf_done_cnt", 32'(done_cnt - d0), 32'd2);
        for (int k = 0; k < 16 && k < q_beats.size(); k++) begin
            chk("pf_cycle", 32'(q_beats[k].stamp), 32'(st + k));
            chk("pf_index", 32'(q_beats[k].idx), (k < 12) ? 32'(k) : 32'(k - 12));
            chk("pf_errcnt", 32'(q_beats[k].ec), (k < 12) ? 32'd0 : 32'd8);
            chk("pf_last", 32'(q_beats[k].last), 32'((k == 11) || (k == 15)));
        end
`endif

        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 7);
            v = {$urandom, $urandom, $urandom};
            if (r == 0)      e = 12'h000;
            else if (r == 1) e = 12'hFFF;
            else             e = 12'($urandom) & 12'($urandom);
            run_vec(v, e, (t % 3 == 0) ? 0 : 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
